// File: rtl/lab_decoder_pkg.sv
// Shared types and helpers for the lab board digit/LED select decoder.
// Widths are sized for the largest select the boards use.
package lab_decoder_pkg;

    localparam int SEL_W_DEF = 2;
    localparam int OUT_W     = 2 ** SEL_W_DEF;
    localparam int MAX_SEL_W = 6;
    localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    function automatic logic [MAX_OUT_W-1:0] onehot(
        input logic [MAX_SEL_W-1:0] sel,
        input logic                 act_low
    );
        logic [MAX_OUT_W-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return act_low ? ~v : v;
    endfunction

endpackage

// File: rtl/lab_scan_timer.sv
// Dwell tick counter for scan mode; strobes advance on the last tick
// of each index. A dwell of 0 behaves like a dwell of 1.
module lab_scan_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    output logic               advance
);

    logic [DWELL_W-1:0] tick;
    logic [DWELL_W-1:0] last;

    // >= so a dwell lowered below the current count advances at once
    assign last    = (dwell == '0) ? '0 : dwell - 1'b1;
    assign advance = run && (tick >= last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= '0;
        end else if (clear) begin
            tick <= '0;
        end else if (advance) begin
            tick <= '0;
        end else if (run) begin
            tick <= tick + 1'b1;
        end
    end

endmodule

// File: rtl/lab_decoder_scan.sv
// Registered one-hot select decoder with direct and auto-scan modes,
// driving multiplexed LED / 7-segment digit selects.
module lab_decoder_scan
    import lab_decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8,
    parameter int ACT_LOW = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel_in,
    input  logic [DWELL_W-1:0]  dwell,
    output logic [2**SEL_W-1:0] dout,
    output logic [SEL_W-1:0]    cur_sel,
    output logic                wrap
);

    localparam int               OUT_N = 2 ** SEL_W;
    localparam logic             AL    = (ACT_LOW != 0);
    localparam logic [SEL_W-1:0] LAST  = '1;

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic                 from_scan;
    logic                 restart;
    logic                 clear;
    logic                 run;
    logic                 advance;
    logic [SEL_W-1:0]     sel_d;
    logic                 wrap_d;
    logic [OUT_N-1:0]     dout_d;
    logic [MAX_OUT_W-1:0] oh_wide;
    logic                 unused_hi;

    always_comb begin
        state_d = ST_IDLE;
        if (enable) begin
            state_d = mode ? ST_SCAN : ST_DIRECT;
        end
    end

    // Scan resumes only if the last active mode before any idle gap was SCAN
    assign restart = (state_q != ST_SCAN) && !from_scan;
    assign clear   = (state_d == ST_DIRECT)
                   || ((state_d == ST_SCAN) && restart);
    assign run     = (state_d == ST_SCAN) && !restart;

    lab_scan_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .run     (run),
        .dwell   (dwell),
        .advance (advance)
    );

    always_comb begin
        sel_d  = cur_sel;
        wrap_d = 1'b0;
        case (state_d)
            ST_DIRECT: sel_d = sel_in;
            ST_SCAN: begin
                if (restart) begin
                    sel_d = '0;
                end else if (advance) begin
                    sel_d  = cur_sel + 1'b1;
                    wrap_d = (cur_sel == LAST);
                end
            end
            default: ;
        endcase
    end

    assign oh_wide   = onehot(MAX_SEL_W'(sel_d), AL);
    assign unused_hi = ^oh_wide[MAX_OUT_W-1:OUT_N];
    assign dout_d    = (state_d == ST_IDLE) ? {OUT_N{AL}}
                                            : oh_wide[OUT_N-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            from_scan <= 1'b0;
            cur_sel   <= '0;
            dout      <= {OUT_N{AL}};
            wrap      <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_sel <= sel_d;
            dout    <= dout_d;
            wrap    <= wrap_d;
            if (state_d == ST_SCAN) begin
                from_scan <= 1'b1;
            end else if (state_d == ST_DIRECT) begin
                from_scan <= 1'b0;
            end
        end
    end

endmodule
